pattern_detector_moore: RTL and testbench

Parametrised Moore-type serial pattern detector. It is the generalised successor of the fixed 4-bit "1101" detector in the FSM lab set. It adds a configurable pattern length, a pattern that can be reloaded at run time, a sample-enable qualifier, a selectable overlap or non-overlap mode, and an optional saturating match counter. It sits after a serial bit source and flags each occurrence of the programmed pattern with a registered, state-derived output.

---
 rtl/pattern_detector_moore.sv | 149 ++++++++++++++
 tb/tb_pattern_detector_moore.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pattern_detector_moore.sv
// -----------------------------------------------------------------------------
// pattern_detector_moore
//
// Parametrised Moore-type serial pattern detector. Accepted bits shift into a
// history register. The found flag is set on the edge where the last N
// accepted bits equal the programmed pattern. A fill counter keeps the flag
// low until N fresh bits have been seen, so the all-zero reset history can
// never match. In non-overlap mode the fill counter restarts after each match.
//
// Optional feature macro: PATTERN_DETECTOR_MATCH_COUNT_EN
//   When defined, a saturating match counter of CNT_W bits is built.
//   When undefined, count is tied to zero and clr_cnt is ignored.
//
// Parameters:
//   N        pattern length in bits (2..16)
//   PATTERN  reset/default pattern; bit N-1 is the first bit received
//   CNT_W    width of the match counter port
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   x         serial data bit
//   en        sample qualifier; x is taken only when en=1
//   overlap   1 = overlapping matches, 0 = each match needs N fresh bits
//   pat_load  load pat_in into the pattern register (wins over en)
//   pat_in    new pattern
//   y         found flag, driven straight from a register
//   count     saturating match count (zero when the counter is not built)
//   clr_cnt   synchronous clear of count (wins over an increment)
// -----------------------------------------------------------------------------
module pattern_detector_moore #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             y,
  output logic [CNT_W-1:0] count,
  input  logic             clr_cnt
);

  // fill must hold the value N itself, hence N+1 codes
  localparam int unsigned    FW       = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N);
  localparam logic [FW-1:0]  FILL_ONE = FW'(1);

  logic [N-1:0]  pat_r,   pat_n;
  logic [N-1:0]  hist_r,  hist_n;
  logic [FW-1:0] fill_r,  fill_n;
  logic          found_r, found_n;

  logic [N-1:0]  h_acc_s;
  logic [FW-1:0] f_acc_s;
  logic          match_s;

  // State register for pattern, history, fill gate and found flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r   <= PATTERN;
      hist_r  <= {N{1'b0}};
      fill_r  <= {FW{1'b0}};
      found_r <= 1'b0;
    end else begin
      pat_r   <= pat_n;
      hist_r  <= hist_n;
      fill_r  <= fill_n;
      found_r <= found_n;
    end
  end

  // Next-state logic: load beats sample, idle holds everything
  always_comb begin
    pat_n   = pat_r;
    hist_n  = hist_r;
    fill_n  = fill_r;
    found_n = found_r;
    match_s = 1'b0;
    h_acc_s = {hist_r[N-2:0], x};
    f_acc_s = (fill_r == FILL_MAX) ? FILL_MAX : (fill_r + FILL_ONE);

    if (pat_load) begin
      // A sample presented together with a load is dropped on purpose
      pat_n   = pat_in;
      fill_n  = {FW{1'b0}};
      found_n = 1'b0;
    end else if (en) begin
      match_s = (f_acc_s == FILL_MAX) && (h_acc_s == pat_r);
      hist_n  = h_acc_s;
      found_n = match_s;
      // overlap only matters on a matching edge: it decides whether the
      // bits of this match may be reused by the next one
      if (match_s && !overlap) begin
        fill_n = {FW{1'b0}};
      end else begin
        fill_n = f_acc_s;
      end
    end else begin
      hist_n = hist_r;
    end
  end

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_r, count_n;

  // Match counter register, updated on the same edge as found
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_n;
    end
  end

  // Counter next value: clear beats increment, increment saturates
  always_comb begin
    count_n = count_r;
    if (clr_cnt) begin
      count_n = {CNT_W{1'b0}};
    end else if (match_s && (count_r != CNT_MAX)) begin
      count_n = count_r + CNT_ONE;
    end else begin
      count_n = count_r;
    end
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
`endif

  // Outputs come straight from registers, no path from x to y
  always_comb begin
    y = found_r;
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    count = count_r;
`else
    count = {CNT_W{1'b0}};
`endif
  end

endmodule

// File: tb/tb_pattern_detector_moore.sv
module tb_pattern_detector_moore;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       en;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       clr_cnt;
  logic       y;
  logic [7:0] count;

  // second instance for counter saturation: N=2, CNT_W=2, pattern 11
  logic       s_pat_load;
  logic [1:0] s_pat_in;
  logic       s_y;
  logic [1:0] s_count;

  int vectors = 0;
  int errors  = 0;

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pattern_detector_moore #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) u_main (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .y(y), .count(count),
    .clr_cnt(clr_cnt)
  );

  pattern_detector_moore #(.N(2), .PATTERN(2'b11), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap),
    .pat_load(s_pat_load), .pat_in(s_pat_in), .y(s_y), .count(s_count),
    .clr_cnt(clr_cnt)
  );

  function automatic logic [15:0] cexp(input int v);
    return CNT_ON ? 16'(v) : 16'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    x = b; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; x = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0; x = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("reset_y", 16'(y), 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; x = 1'b0; en = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; clr_cnt = 1'b0;
    s_pat_load = 1'b0; s_pat_in = 2'b00;

    // reset state
    @(posedge clk); #1;
    chk("rst_y", 16'(y), 16'd0);
    chk("rst_count", 16'(count), 16'd0);
    reset = 1'b1;

    // reset mid-stream
    send(1'b1); send(1'b1); send(1'b0);
    chk("mid_pre_y", 16'(y), 16'd0);
    reset = 1'b0;
    #4;
    chk("mid_in_rst_y", 16'(y), 16'd0);
    reset = 1'b1;
    send(1'b1); chk("mid_after_y", 16'(y), 16'd0);
    send(1'b1); chk("mid_b1", 16'(y), 16'd0);
    send(1'b1); chk("mid_b2", 16'(y), 16'd0);
    send(1'b0); chk("mid_b3", 16'(y), 16'd0);
    send(1'b1); chk("mid_b4", 16'(y), 16'd1);
    chk("mid_count", 16'(count), cexp(1));

    // overlap mode, input 1101101
    do_reset();
    overlap = 1'b1;
    send(1'b1); chk("ov_b1", 16'(y), 16'd0);
    send(1'b1); chk("ov_b2", 16'(y), 16'd0);
    send(1'b0); chk("ov_b3", 16'(y), 16'd0);
    send(1'b1); chk("ov_b4", 16'(y), 16'd1);
    send(1'b1); chk("ov_b5", 16'(y), 16'd0);
    send(1'b0); chk("ov_b6", 16'(y), 16'd0);
    send(1'b1); chk("ov_b7", 16'(y), 16'd1);
    chk("ov_count", 16'(count), cexp(2));

    // non-overlap mode, input 1101101
    do_reset();
    overlap = 1'b0;
    send(1'b1); send(1'b1); send(1'b0);
    send(1'b1); chk("nov_b4", 16'(y), 16'd1);
    send(1'b1); chk("nov_b5", 16'(y), 16'd0);
    send(1'b0); chk("nov_b6", 16'(y), 16'd0);
    send(1'b1); chk("nov_b7", 16'(y), 16'd0);
    chk("nov_count", 16'(count), cexp(1));

    // enable gating
    do_reset();
    overlap = 1'b1;
    send(1'b1); send(1'b1);
    idle(3); chk("en_idle_y", 16'(y), 16'd0);
    send(1'b0); chk("en_b3", 16'(y), 16'd0);
    send(1'b1); chk("en_b4", 16'(y), 16'd1);
    idle(2); chk("en_hold_y", 16'(y), 16'd1);
    chk("en_count", 16'(count), cexp(1));

    // pattern reload with a colliding sample
    pat_in = 4'b0110; pat_load = 1'b1; en = 1'b1; x = 1'b1;
    @(posedge clk); #1;
    pat_load = 1'b0; en = 1'b0; x = 1'b0;
    chk("ld_y", 16'(y), 16'd0);
    send(1'b0); chk("ld_b1", 16'(y), 16'd0);
    send(1'b1); chk("ld_b2", 16'(y), 16'd0);
    send(1'b1); chk("ld_b3", 16'(y), 16'd0);
    send(1'b0); chk("ld_b4", 16'(y), 16'd1);
    chk("ld_count", 16'(count), cexp(2));

    // fill gate with all-zero pattern
    do_reset();
    pat_in = 4'b0000; pat_load = 1'b1;
    @(posedge clk); #1;
    pat_load = 1'b0;
    send(1'b0); chk("z_b1", 16'(y), 16'd0);
    send(1'b0); chk("z_b2", 16'(y), 16'd0);
    send(1'b0); chk("z_b3", 16'(y), 16'd0);
    send(1'b0); chk("z_b4", 16'(y), 16'd1);

    // counter saturation and clear on the N=2 instance
    do_reset();
    overlap = 1'b1;
    send(1'b1); chk("sat_b1_y", 16'(s_y), 16'd0);
    send(1'b1); chk("sat_c1", 16'(s_count), cexp(1));
    send(1'b1); chk("sat_c2", 16'(s_count), cexp(2));
    send(1'b1); chk("sat_c3", 16'(s_count), cexp(3));
    send(1'b1); chk("sat_c4", 16'(s_count), cexp(3));
    send(1'b1); chk("sat_c5", 16'(s_count), cexp(3));
    chk("sat_y", 16'(s_y), 16'd1);
    clr_cnt = 1'b1;
    send(1'b1);
    clr_cnt = 1'b0;
    chk("clr_count", 16'(s_count), 16'd0);
    chk("clr_y", 16'(s_y), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
